// File: rtl/alu_pkg.sv
// Shared constants for the ID/EX ALU issue stage: ALU select codes, opcode/funct
// values, operand-source selects and the default widths.
package alu_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_SEL_WIDTH  = 4;
    localparam int DEF_REG_ADDR_W = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_XOR = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SGT = 4'b1001;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SGT  = 6'b101100;

    typedef enum logic [1:0] {
        OP1_ZERO = 2'd0,
        OP1_RS   = 2'd1,
        OP1_RT   = 2'd2
    } op1Sel_e;

    typedef enum logic [1:0] {
        OP2_ZERO = 2'd0,
        OP2_RT   = 2'd1,
        OP2_SEXT = 2'd2,
        OP2_ZEXT = 2'd3
    } op2Sel_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational instruction decoder: produces the ALU select, operand-source
// selects, destination register and write/memory/illegal control bits.
module alu_decode
    import alu_pkg::*;
#(
    parameter int SEL_WIDTH  = DEF_SEL_WIDTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [31:0]           i_instr,
    output logic [SEL_WIDTH-1:0]  o_opsel,
    output logic [1:0]            o_op1Sel,
    output logic [1:0]            o_op2Sel,
    output logic [REG_ADDR_W-1:0] o_rdAddr,
    output logic                  o_regWrite,
    output logic                  o_memRead,
    output logic                  o_memWrite,
    output logic                  o_illegal
);

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [3:0] w_opsel;
    logic [1:0] w_op1Sel;
    logic [1:0] w_op2Sel;
    logic [4:0] w_rd;
    logic       w_regWrite;
    logic       w_memRead;
    logic       w_memWrite;
    logic       w_illegal;
    logic       w_unusedFields;

    assign w_opcode       = i_instr[31:26];
    assign w_funct        = i_instr[5:0];
    assign w_unusedFields = ^{i_instr[25:21], i_instr[10:6]};

    always_comb begin
        w_opsel    = ALU_ADD;
        w_op1Sel   = OP1_ZERO;
        w_op2Sel   = OP2_ZERO;
        w_rd       = 5'd0;
        w_regWrite = 1'b0;
        w_memRead  = 1'b0;
        w_memWrite = 1'b0;
        w_illegal  = 1'b0;

        case (w_opcode)
            OP_RTYPE: begin
                w_op1Sel   = OP1_RS;
                w_op2Sel   = OP2_RT;
                w_rd       = i_instr[15:11];
                w_regWrite = 1'b1;
                case (w_funct)
                    FN_ADD, FN_ADDU: w_opsel = ALU_ADD;
                    FN_SUB, FN_SUBU: w_opsel = ALU_SUB;
                    FN_AND:          w_opsel = ALU_AND;
                    FN_OR:           w_opsel = ALU_OR;
                    FN_XOR:          w_opsel = ALU_XOR;
                    FN_NOR:          w_opsel = ALU_NOR;
                    FN_SLT:          w_opsel = ALU_SLT;
                    FN_SGT:          w_opsel = ALU_SGT;
                    // Shifts take the value from rt; the ALU picks shamt out of op2[10:6].
                    FN_SLL: begin
                        w_opsel  = ALU_SLL;
                        w_op1Sel = OP1_RT;
                        w_op2Sel = OP2_ZEXT;
                    end
                    FN_SRL: begin
                        w_opsel  = ALU_SRL;
                        w_op1Sel = OP1_RT;
                        w_op2Sel = OP2_ZEXT;
                    end
                    default: w_illegal = 1'b1;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                w_op2Sel   = OP2_SEXT;
                w_regWrite = 1'b1;
            end
            OP_SLTI: begin
                w_opsel    = ALU_SLT;
                w_op2Sel   = OP2_SEXT;
                w_regWrite = 1'b1;
            end
            OP_ANDI: begin
                w_opsel    = ALU_AND;
                w_op2Sel   = OP2_ZEXT;
                w_regWrite = 1'b1;
            end
            OP_ORI: begin
                w_opsel    = ALU_OR;
                w_op2Sel   = OP2_ZEXT;
                w_regWrite = 1'b1;
            end
            OP_XORI: begin
                w_opsel    = ALU_XOR;
                w_op2Sel   = OP2_ZEXT;
                w_regWrite = 1'b1;
            end
            OP_LW: begin
                w_op2Sel   = OP2_SEXT;
                w_memRead  = 1'b1;
                w_regWrite = 1'b1;
            end
            OP_SW: begin
                w_op2Sel   = OP2_SEXT;
                w_memWrite = 1'b1;
            end
            OP_BEQ: begin
                w_opsel  = ALU_SUB;
                w_op2Sel = OP2_RT;
            end
            default: w_illegal = 1'b1;
        endcase

        if (w_opcode != OP_RTYPE) begin
            w_op1Sel = OP1_RS;
            w_rd     = i_instr[20:16];
        end

        // Undecodable words issue as a harmless ADD of zeros with no side effects.
        if (w_illegal) begin
            w_opsel    = ALU_ADD;
            w_op1Sel   = OP1_ZERO;
            w_op2Sel   = OP2_ZERO;
            w_rd       = 5'd0;
            w_regWrite = 1'b0;
            w_memRead  = 1'b0;
            w_memWrite = 1'b0;
        end

        if (w_rd == 5'd0) begin
            w_regWrite = 1'b0;
        end
    end

    assign o_opsel    = SEL_WIDTH'(w_opsel);
    assign o_op1Sel   = w_op1Sel;
    assign o_op2Sel   = w_op2Sel;
    assign o_rdAddr   = REG_ADDR_W'(w_rd);
    assign o_regWrite = w_regWrite;
    assign o_memRead  = w_memRead;
    assign o_memWrite = w_memWrite;
    assign o_illegal  = w_illegal;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes, builds ALU operands and registers them with stall/flush.
// Define ALU_ISSUE_FWD_EN to add the EX/MEM forwarding ports (fwd_valid/fwd_rd/fwd_data).
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SEL_WIDTH  = DEF_SEL_WIDTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [31:0]           id_instr,
    input  logic [DATA_WIDTH-1:0] id_rs_data,
    input  logic [DATA_WIDTH-1:0] id_rt_data,
`ifdef ALU_ISSUE_FWD_EN
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_rd,
    input  logic [DATA_WIDTH-1:0] fwd_data,
`endif
    input  logic                  stall,
    input  logic                  flush,
    output logic                  ex_valid,
    output logic [SEL_WIDTH-1:0]  ex_opsel,
    output logic [DATA_WIDTH-1:0] ex_operand1,
    output logic [DATA_WIDTH-1:0] ex_operand2,
    output logic [REG_ADDR_W-1:0] ex_rd_addr,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_illegal,
    output logic [15:0]           illegal_cnt
);

    logic [SEL_WIDTH-1:0]  w_opsel;
    logic [1:0]            w_op1Sel;
    logic [1:0]            w_op2Sel;
    logic [REG_ADDR_W-1:0] w_rdAddr;
    logic                  w_regWrite;
    logic                  w_memRead;
    logic                  w_memWrite;
    logic                  w_illegal;
    logic [DATA_WIDTH-1:0] w_rsData;
    logic [DATA_WIDTH-1:0] w_rtData;
    logic [DATA_WIDTH-1:0] w_sextImm;
    logic [DATA_WIDTH-1:0] w_zextImm;
    logic [DATA_WIDTH-1:0] w_operand1;
    logic [DATA_WIDTH-1:0] w_operand2;
    logic                  w_load;

    logic                  r_valid;
    logic [SEL_WIDTH-1:0]  r_opsel;
    logic [DATA_WIDTH-1:0] r_operand1;
    logic [DATA_WIDTH-1:0] r_operand2;
    logic [REG_ADDR_W-1:0] r_rdAddr;
    logic                  r_regWrite;
    logic                  r_memRead;
    logic                  r_memWrite;
    logic                  r_illegal;
    logic [15:0]           r_illegalCnt;

    alu_decode #(
        .SEL_WIDTH (SEL_WIDTH),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_decode (
        .i_instr   (id_instr),
        .o_opsel   (w_opsel),
        .o_op1Sel  (w_op1Sel),
        .o_op2Sel  (w_op2Sel),
        .o_rdAddr  (w_rdAddr),
        .o_regWrite(w_regWrite),
        .o_memRead (w_memRead),
        .o_memWrite(w_memWrite),
        .o_illegal (w_illegal)
    );

`ifdef ALU_ISSUE_FWD_EN
    logic [REG_ADDR_W-1:0] w_rsAddr;
    logic [REG_ADDR_W-1:0] w_rtAddr;

    assign w_rsAddr = REG_ADDR_W'(id_instr[25:21]);
    assign w_rtAddr = REG_ADDR_W'(id_instr[20:16]);
    // Register 0 is hardwired, so a result aimed at it must never be forwarded.
    assign w_rsData = (fwd_valid && (fwd_rd != '0) && (fwd_rd == w_rsAddr)) ? fwd_data : id_rs_data;
    assign w_rtData = (fwd_valid && (fwd_rd != '0) && (fwd_rd == w_rtAddr)) ? fwd_data : id_rt_data;
`else
    assign w_rsData = id_rs_data;
    assign w_rtData = id_rt_data;
`endif

    assign w_sextImm = {{(DATA_WIDTH-16){id_instr[15]}}, id_instr[15:0]};
    assign w_zextImm = {{(DATA_WIDTH-16){1'b0}}, id_instr[15:0]};

    always_comb begin
        w_operand1 = '0;
        case (w_op1Sel)
            OP1_RS:  w_operand1 = w_rsData;
            OP1_RT:  w_operand1 = w_rtData;
            default: w_operand1 = '0;
        endcase
    end

    always_comb begin
        w_operand2 = '0;
        case (w_op2Sel)
            OP2_RT:   w_operand2 = w_rtData;
            OP2_SEXT: w_operand2 = w_sextImm;
            OP2_ZEXT: w_operand2 = w_zextImm;
            default:  w_operand2 = '0;
        endcase
    end

    assign w_load = !flush && !stall;

    // Flush only kills the control bits; the data fields simply hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_opsel    <= '0;
            r_operand1 <= '0;
            r_operand2 <= '0;
            r_rdAddr   <= '0;
            r_regWrite <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regWrite <= 1'b0;
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (!stall) begin
            r_valid    <= id_valid;
            r_opsel    <= w_opsel;
            r_operand1 <= w_operand1;
            r_operand2 <= w_operand2;
            r_rdAddr   <= w_rdAddr;
            r_regWrite <= id_valid && w_regWrite;
            r_memRead  <= id_valid && w_memRead;
            r_memWrite <= id_valid && w_memWrite;
            r_illegal  <= id_valid && w_illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegalCnt <= '0;
        end else if (w_load && id_valid && w_illegal && (r_illegalCnt != 16'hFFFF)) begin
            r_illegalCnt <= r_illegalCnt + 16'd1;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_opsel     = r_opsel;
    assign ex_operand1  = r_operand1;
    assign ex_operand2  = r_operand2;
    assign ex_rd_addr   = r_rdAddr;
    assign ex_reg_write = r_regWrite;
    assign ex_mem_read  = r_memRead;
    assign ex_mem_write = r_memWrite;
    assign ex_illegal   = r_illegal;
    assign illegal_cnt  = r_illegalCnt;

endmodule
